// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared definitions for the MEM-stage exception controller.
//   - exception codes reported to CP0
//   - exception vector address
//   - controller FSM state encoding
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_CODE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_CODE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_CODE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_CODE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_CODE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_CODE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_CODE_ERET  = 32'h0000_000e;
  localparam logic [31:0] EXC_CODE_ADES  = 32'h0000_0005;

  localparam logic [31:0] EXC_VECTOR     = 32'hBFC0_0380;

  // Index of each cause inside the 8-bit flag vector.
  localparam int FLG_ADEL_FETCH = 0;
  localparam int FLG_RI         = 1;
  localparam int FLG_OV         = 2;
  localparam int FLG_SYSCALL    = 3;
  localparam int FLG_BREAK      = 4;
  localparam int FLG_ERET       = 5;
  localparam int FLG_ADEL_DATA  = 6;
  localparam int FLG_ADES       = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_COMMIT = 2'd2,
    S_SETTLE = 2'd3
  } exc_state_t;

endpackage

// File: rtl/exc_prio.sv
// exc_prio: combinational exception priority encoder.
// Ports:
//   flags_i     - {ades, adel_data, eret, break, syscall, ov, ri, adel_fetch}
//   int_pend_i  - qualified interrupt pending (highest priority)
//   pc_i        - instruction address (bad address for fetch errors)
//   data_addr_i - data address (bad address for load/store errors)
//   code_o      - exception code of the winning cause, 0 if none
//   bad_addr_o  - faulting address of the winning cause, 0 if not an address error
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic [7:0]  flags_i,
  input  logic        int_pend_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_addr_i,
  output logic [31:0] code_o,
  output logic [31:0] bad_addr_o
);

  always_comb begin
    code_o     = '0;
    bad_addr_o = '0;
    if (int_pend_i) begin
      code_o = EXC_CODE_INT;
    end else if (flags_i[FLG_ADEL_FETCH]) begin
      code_o     = EXC_CODE_ADEL;
      bad_addr_o = pc_i;
    end else if (flags_i[FLG_RI]) begin
      code_o = EXC_CODE_RI;
    end else if (flags_i[FLG_OV]) begin
      code_o = EXC_CODE_OV;
    end else if (flags_i[FLG_SYSCALL]) begin
      code_o = EXC_CODE_SYS;
    end else if (flags_i[FLG_BREAK]) begin
      code_o = EXC_CODE_BP;
    end else if (flags_i[FLG_ERET]) begin
      code_o = EXC_CODE_ERET;
    end else if (flags_i[FLG_ADEL_DATA]) begin
      code_o     = EXC_CODE_ADEL;
      bad_addr_o = data_addr_i;
    end else if (flags_i[FLG_ADES]) begin
      code_o     = EXC_CODE_ADES;
      bad_addr_o = data_addr_i;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception controller. Detects an exception, waits for
// outstanding bus/divider activity to drain, then commits it to CP0 for one
// cycle while flushing and redirecting the pipeline.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   inst_valid_i, exc_flags_i, pc_i, in_delayslot_i, data_addr_i - MEM stage info
//   status_i, cause_i, epc_i - current CP0 registers
//   drain_busy_i             - outstanding bus access or divider busy
//   excepttype_o, current_inst_addr_o, bad_addr_o, is_in_delayslot_o - to CP0
//   stall_o, flush_o, redirect_o, newpc_o - pipeline control
//   timeout_o                - sticky drain timeout flag
// Optional feature: define EXC_DRAIN_TIMEOUT_EN to bound DRAIN to 255 cycles.
//
// state  | meaning
// IDLE   | waiting for an exception in MEM
// DRAIN  | exception latched, waiting for drain_busy_i to drop
// COMMIT | one cycle: report to CP0, flush and redirect
// SETTLE | one cycle: let the redirect take effect, detection ignored
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        drain_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic [31:0] bad_addr_o,
  output logic        is_in_delayslot_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] newpc_o,
  output logic        timeout_o
);

  exc_state_t  r_state, w_next;
  logic        w_int_pend, w_detect, w_to_hit, w_timeout;
  logic [31:0] w_code, w_bad;
  logic [31:0] r_code, r_pc, r_bad;
  logic        r_ds;
  logic        w_unused;

  assign w_int_pend = ((cause_i[15:8] & status_i[15:8]) != 8'd0) && status_i[0] && !status_i[1];
  assign w_detect   = inst_valid_i && (w_int_pend || (exc_flags_i != 8'd0));
  assign w_unused   = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  exc_prio u_prio (
    .flags_i     (exc_flags_i),
    .int_pend_i  (w_int_pend),
    .pc_i        (pc_i),
    .data_addr_i (data_addr_i),
    .code_o      (w_code),
    .bad_addr_o  (w_bad)
  );

`ifdef EXC_DRAIN_TIMEOUT_EN
  logic [7:0] r_drain_cnt;
  logic       r_timeout;

  // Counter holds the number of DRAIN cycles already completed, so 254 means
  // the current cycle is the 255th.
  assign w_to_hit  = (r_drain_cnt == 8'd254);
  assign w_timeout = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 8'd1 : 8'd0;
      if ((r_state == S_DRAIN) && w_to_hit && drain_busy_i)
        r_timeout <= 1'b1;
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign w_timeout = 1'b0;
`endif

  assign timeout_o = w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_pc    <= '0;
      r_bad   <= '0;
      r_ds    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_detect) begin
        r_code <= w_code;
        r_pc   <= pc_i;
        r_bad  <= w_bad;
        r_ds   <= in_delayslot_i;
      end
    end
  end

  always_comb begin
    w_next              = r_state;
    stall_o             = 1'b0;
    flush_o             = 1'b0;
    redirect_o          = 1'b0;
    excepttype_o        = '0;
    current_inst_addr_o = '0;
    bad_addr_o          = '0;
    is_in_delayslot_o   = 1'b0;
    newpc_o             = '0;
    case (r_state)
      S_IDLE: begin
        if (w_detect) begin
          // A detect under reset is discarded, so do not stall for it.
          stall_o = !rst;
          w_next  = drain_busy_i ? S_DRAIN : S_COMMIT;
        end
      end
      S_DRAIN: begin
        stall_o = 1'b1;
        if (!drain_busy_i || w_to_hit)
          w_next = S_COMMIT;
      end
      S_COMMIT: begin
        stall_o             = 1'b1;
        flush_o             = 1'b1;
        redirect_o          = 1'b1;
        excepttype_o        = r_code;
        current_inst_addr_o = r_pc;
        bad_addr_o          = r_bad;
        is_in_delayslot_o   = r_ds;
        newpc_o             = (r_code == EXC_CODE_ERET) ? epc_i : EXC_VECTOR;
        w_next              = S_SETTLE;
      end
      S_SETTLE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [7:0]  exc_flags_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] data_addr_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        drain_busy_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, stall_o, flush_o, redirect_o, timeout_o;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_valid_i        (inst_valid_i),
    .exc_flags_i         (exc_flags_i),
    .pc_i                (pc_i),
    .in_delayslot_i      (in_delayslot_i),
    .data_addr_i         (data_addr_i),
    .status_i            (status_i),
    .cause_i             (cause_i),
    .epc_i               (epc_i),
    .drain_busy_i        (drain_busy_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .bad_addr_o          (bad_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .redirect_o          (redirect_o),
    .newpc_o             (newpc_o),
    .timeout_o           (timeout_o)
  );

  localparam logic [31:0] VEC = 32'hBFC00380;
`ifdef EXC_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a pending-exception record plus phase flags.
  bit          m_drain, m_commit, m_settle, m_timeout;
  int          m_cnt;
  logic [31:0] m_code, m_pc, m_bad;
  bit          m_ds;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] code_of(input int idx);
    case (idx)
      0: return 32'h4;  1: return 32'ha;  2: return 32'hc;  3: return 32'h8;
      4: return 32'h9;  5: return 32'he;  6: return 32'h4;  default: return 32'h5;
    endcase
  endfunction

  function automatic bit int_pend(input logic [31:0] c, input logic [31:0] s);
    return ((c[15:8] & s[15:8]) != 0) && s[0] && !s[1];
  endfunction

  function automatic void ref_prio(input logic [7:0] f, input bit intp, input logic [31:0] pc,
                                   input logic [31:0] da, output logic [31:0] code,
                                   output logic [31:0] bad);
    code = 0;
    bad  = 0;
    if (intp) begin
      code = 32'h1;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (f[i]) begin
        code = code_of(i);
        bad  = (i == 0) ? pc : (i >= 6) ? da : 32'h0;
        return;
      end
    end
  endfunction

  task automatic model_check();
    bit idle, det;
    det  = inst_valid_i && (int_pend(cause_i, status_i) || exc_flags_i != 0);
    idle = !(m_drain || m_commit || m_settle);
    chk("m_stall", {31'b0, stall_o}, {31'b0, (idle && det && !rst) || m_drain || m_commit});
    chk("m_flush", {31'b0, flush_o}, {31'b0, m_commit});
    chk("m_redirect", {31'b0, redirect_o}, {31'b0, m_commit});
    chk("m_excepttype", excepttype_o, m_commit ? m_code : 32'h0);
    chk("m_inst_addr", current_inst_addr_o, m_commit ? m_pc : 32'h0);
    chk("m_bad_addr", bad_addr_o, m_commit ? m_bad : 32'h0);
    chk("m_delayslot", {31'b0, is_in_delayslot_o}, {31'b0, m_commit && m_ds});
    chk("m_newpc", newpc_o, !m_commit ? 32'h0 : (m_code == 32'he) ? epc_i : VEC);
    chk("m_timeout", {31'b0, timeout_o}, {31'b0, m_timeout});
  endtask

  task automatic model_update();
    bit det;
    det = inst_valid_i && (int_pend(cause_i, status_i) || exc_flags_i != 0);
    if (rst) begin
      m_drain = 0; m_commit = 0; m_settle = 0; m_timeout = 0; m_cnt = 0;
      m_code = 0; m_pc = 0; m_bad = 0; m_ds = 0;
    end else if (m_commit) begin
      m_commit = 0;
      m_settle = 1;
    end else if (m_settle) begin
      m_settle = 0;
    end else if (m_drain) begin
      m_cnt++;
      if (!drain_busy_i || (TO_EN && m_cnt == 255)) begin
        if (drain_busy_i) m_timeout = 1;
        m_drain  = 0;
        m_commit = 1;
      end
    end else if (det) begin
      ref_prio(exc_flags_i, int_pend(cause_i, status_i), pc_i, data_addr_i, m_code, m_bad);
      m_pc = pc_i;
      m_ds = in_delayslot_i;
      if (drain_busy_i) begin
        m_drain = 1;
        m_cnt   = 0;
      end else begin
        m_commit = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    inst_valid_i = 0; exc_flags_i = 0; drain_busy_i = 0; in_delayslot_i = 0;
    status_i = 0; cause_i = 0;
  endtask

  typedef struct {
    logic [7:0]  flags;
    logic [31:0] cause, status, pc, daddr, epc;
    logic        ds;
    logic        det;
    logic [31:0] code, bad, newpc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int stall_cnt, commit_at, flush_cnt;

    vecs[0]  = '{8'h04, 32'h0, 32'h0, 32'hBFC00100, 32'h0, 32'h0, 1'b0, 1'b1, 32'hc, 32'h0, VEC};
    vecs[1]  = '{8'h20, 32'h0, 32'h0, 32'hBFC00050, 32'h0, 32'hBFC00200, 1'b0, 1'b1, 32'he, 32'h0, 32'hBFC00200};
    vecs[2]  = '{8'h02, 32'h8000, 32'h8001, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 32'h0, VEC};
    vecs[3]  = '{8'h02, 32'h8000, 32'h8003, 32'h104, 32'h0, 32'h0, 1'b0, 1'b1, 32'ha, 32'h0, VEC};
    vecs[4]  = '{8'h01, 32'h0, 32'h0, 32'h00001001, 32'h77, 32'h0, 1'b1, 1'b1, 32'h4, 32'h00001001, VEC};
    vecs[5]  = '{8'hFF, 32'h0, 32'h0, 32'h2000, 32'h3000, 32'h0, 1'b0, 1'b1, 32'h4, 32'h2000, VEC};
    vecs[6]  = '{8'hC0, 32'h0, 32'h0, 32'h2004, 32'h22, 32'h0, 1'b0, 1'b1, 32'h4, 32'h22, VEC};
    vecs[7]  = '{8'h80, 32'h0, 32'h0, 32'h2008, 32'h3, 32'h0, 1'b1, 1'b1, 32'h5, 32'h3, VEC};
    vecs[8]  = '{8'h18, 32'h0, 32'h0, 32'h200c, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0, VEC};
    vecs[9]  = '{8'h10, 32'h0, 32'h0, 32'h2010, 32'h0, 32'h0, 1'b0, 1'b1, 32'h9, 32'h0, VEC};
    vecs[10] = '{8'h00, 32'h8000, 32'h8000, 32'h2014, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{8'h24, 32'h0100, 32'h0101, 32'h2018, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 32'h0, VEC};

    quiet();
    rst = 1; pc_i = 0; data_addr_i = 0; epc_i = 0;
    m_drain = 0; m_commit = 0; m_settle = 0; m_timeout = 0; m_cnt = 0;
    m_code = 0; m_pc = 0; m_bad = 0; m_ds = 0;
    #1;
    repeat (3) cycle();
    chk("rst_excepttype", excepttype_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_newpc", newpc_o, 32'h0);
    chk("rst_timeout", {31'b0, timeout_o}, 32'h0);
    rst = 0;
    cycle();

    // Table-driven single exceptions with no drain wait.
    for (int i = 0; i < 12; i++) begin
      inst_valid_i = 1; exc_flags_i = vecs[i].flags; cause_i = vecs[i].cause;
      status_i = vecs[i].status; pc_i = vecs[i].pc; data_addr_i = vecs[i].daddr;
      epc_i = vecs[i].epc; in_delayslot_i = vecs[i].ds; drain_busy_i = 0;
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, stall_o}, {31'b0, vecs[i].det});
      cycle();
      quiet();
      #1;
      chk($sformatf("v%0d_code", i), excepttype_o, vecs[i].code);
      chk($sformatf("v%0d_bad", i), bad_addr_o, vecs[i].bad);
      chk($sformatf("v%0d_newpc", i), newpc_o, vecs[i].newpc);
      chk($sformatf("v%0d_pc", i), current_inst_addr_o, vecs[i].det ? vecs[i].pc : 32'h0);
      chk($sformatf("v%0d_ds", i), {31'b0, is_in_delayslot_o}, {31'b0, vecs[i].det & vecs[i].ds});
      chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].det});
      cycle();
      chk($sformatf("v%0d_flush_once", i), {31'b0, flush_o}, 32'h0);
      cycle();
    end

    // ades with drain_busy high for three cycles starting at detect:
    // detect, three DRAIN cycles (last one sees busy low), then COMMIT.
    stall_cnt = 0; commit_at = -1;
    for (int i = 0; i < 8; i++) begin
      inst_valid_i = (i == 0); exc_flags_i = (i == 0) ? 8'h80 : 8'h00;
      data_addr_i = 32'h3; pc_i = 32'h3000; drain_busy_i = (i < 3);
      #1;
      if (stall_o) stall_cnt++;
      if (flush_o) begin
        commit_at = i;
        chk("busy_bad_addr", bad_addr_o, 32'h3);
        chk("busy_code", excepttype_o, 32'h5);
      end
      cycle();
    end
    chk("busy_stall_cycles", stall_cnt, 5);
    chk("busy_commit_cycle", commit_at, 4);
    quiet();

    // Inputs seen during DRAIN must not replace the latched exception.
    inst_valid_i = 1; exc_flags_i = 8'h04; pc_i = 32'hA000; drain_busy_i = 1;
    cycle();
    exc_flags_i = 8'h21; pc_i = 32'hB000; in_delayslot_i = 1; data_addr_i = 32'h55;
    cycle();
    drain_busy_i = 0;
    cycle();
    #1;
    chk("latch_code", excepttype_o, 32'hc);
    chk("latch_pc", current_inst_addr_o, 32'hA000);
    chk("latch_ds", {31'b0, is_in_delayslot_o}, 32'h0);
    quiet();
    repeat (3) cycle();

    // Reset in the middle of DRAIN.
    inst_valid_i = 1; exc_flags_i = 8'h08; pc_i = 32'hC000; drain_busy_i = 1;
    cycle();
    inst_valid_i = 0; exc_flags_i = 0;
    cycle();
    rst = 1;
    cycle();
    #1;
    chk("rstdrain_stall", {31'b0, stall_o}, 32'h0);
    chk("rstdrain_flush", {31'b0, flush_o}, 32'h0);
    chk("rstdrain_code", excepttype_o, 32'h0);
    rst = 0; drain_busy_i = 0;
    flush_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (flush_o) flush_cnt++;
      cycle();
    end
    chk("rstdrain_no_commit", flush_cnt, 0);

    // drain_busy stuck high.
    inst_valid_i = 1; exc_flags_i = 8'h04; pc_i = 32'hD000; drain_busy_i = 1;
    commit_at = -1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (flush_o && commit_at < 0) commit_at = i;
      cycle();
      inst_valid_i = 0; exc_flags_i = 0;
    end
`ifdef EXC_DRAIN_TIMEOUT_EN
    chk("to_commit_cycle", commit_at, 256);
    chk("to_sticky", {31'b0, timeout_o}, 32'h1);
`else
    chk("nto_no_commit", commit_at, -1);
    chk("nto_timeout", {31'b0, timeout_o}, 32'h0);
`endif
    rst = 1;
    cycle();
    rst = 0; drain_busy_i = 0;
    #1;
    chk("to_cleared", {31'b0, timeout_o}, 32'h0);
    cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      inst_valid_i   = ($urandom_range(0, 9) < 7);
      exc_flags_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                       ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      status_i       = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cause_i        = ($urandom_range(0, 3) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      pc_i           = $urandom;
      data_addr_i    = $urandom;
      epc_i          = $urandom;
      in_delayslot_i = 1'($urandom);
      drain_busy_i   = 1'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
